// File: rtl/gowin_msi_requester.sv
`default_nettype none
// ============================================================================
// gowin_msi_requester: sticky per-vector interrupt capture with round-robin
// MSI issue, ack timeout, back-off and retry-limit drop.
// Revision: 1.0
// ============================================================================
module gowin_msi_requester #(
  parameter int C_NUM_VECTORS = 4,
  parameter int C_ACK_TIMEOUT = 1024,
  parameter int C_BACKOFF     = 16,
  parameter int C_RETRY_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_msi_enable,
  input  logic [C_NUM_VECTORS-1:0] irq_pulse,
  output logic                     msi_en,
  output logic                     msi_req,
  output logic [4:0]               msinum,
  input  logic                     msi_ack,
  output logic [C_NUM_VECTORS-1:0] pending,
  output logic                     irq_dropped,
  output logic                     busy
);

  localparam int C_VEC_W = (C_NUM_VECTORS > 1) ? $clog2(C_NUM_VECTORS) : 1;
  localparam int C_TMO_W = $clog2(C_ACK_TIMEOUT);
  localparam int C_BO_W  = (C_BACKOFF > 1) ? $clog2(C_BACKOFF) : 1;
  localparam int C_RTY_W = $clog2(C_RETRY_LIMIT + 1);

  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(C_ACK_TIMEOUT - 1);
  localparam logic [C_BO_W-1:0]  C_BO_LAST  = C_BO_W'(C_BACKOFF - 1);
  localparam logic [C_RTY_W-1:0] C_RTY_LAST = C_RTY_W'(C_RETRY_LIMIT - 1);
  localparam logic [C_VEC_W-1:0] C_VEC_LAST = C_VEC_W'(C_NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GAP     = 2'd2,
    S_BACKOFF = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [C_NUM_VECTORS-1:0]   pending_q, pending_d;
  logic [C_VEC_W-1:0]         ptr_q, ptr_d;
  logic [C_RTY_W-1:0]         retry_q, retry_d;
  logic [C_TMO_W-1:0]         tmo_q, tmo_d;
  logic [C_BO_W-1:0]          bo_q, bo_d;
  logic [4:0]                 msinum_q, msinum_d;
  logic                       msi_req_q, msi_req_d;
  logic                       msi_en_q, msi_en_d;
  logic                       drop_q, drop_d;
  logic                       cfg_en_q;

  logic                       sel_found;
  logic [C_VEC_W-1:0]         sel_idx;
  logic [C_VEC_W-1:0]         cur_sel;
  logic [C_VEC_W-1:0]         ptr_inc;
  logic                       clr_hit;
  logic [C_NUM_VECTORS-1:0]   clr_mask;

  assign cur_sel = msinum_q[C_VEC_W-1:0];
  assign ptr_inc = (cur_sel == C_VEC_LAST) ? '0 : cur_sel + 1'b1;

  // First pending vector at or after the pointer, wrapping around.
  always_comb begin
    logic [C_VEC_W:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = 0; k < C_NUM_VECTORS; k++) begin
      idx = {1'b0, ptr_q} + (C_VEC_W+1)'(k);
      if (idx >= (C_VEC_W+1)'(C_NUM_VECTORS)) begin
        idx = idx - (C_VEC_W+1)'(C_NUM_VECTORS);
      end
      if (!sel_found && pending_q[idx[C_VEC_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[C_VEC_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    bo_d      = bo_q;
    msinum_d  = msinum_q;
    msi_req_d = 1'b0;
    drop_d    = 1'b0;
    clr_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_en_q && sel_found) begin
          msinum_d  = 5'(sel_idx);
          msi_req_d = 1'b1;
          tmo_d     = '0;
          // Retries count only while the same vector keeps timing out.
          if (sel_idx != cur_sel) begin
            retry_d = '0;
          end
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        msi_req_d = 1'b1;
        if (msi_ack) begin
          clr_hit   = 1'b1;
          ptr_d     = ptr_inc;
          retry_d   = '0;
          msi_req_d = 1'b0;
          state_d   = S_GAP;
        end else if (tmo_q == C_TMO_LAST) begin
          msi_req_d = 1'b0;
          bo_d      = '0;
          state_d   = S_BACKOFF;
          if (retry_q == C_RTY_LAST) begin
            clr_hit = 1'b1;
            drop_d  = 1'b1;
            retry_d = '0;
            ptr_d   = ptr_inc;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      S_BACKOFF: begin
        if (bo_q == C_BO_LAST) begin
          state_d = S_IDLE;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A new pulse wins over a same-cycle clear so the event is not lost.
  always_comb begin
    clr_mask = '0;
    if (clr_hit) begin
      clr_mask[cur_sel] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask) | irq_pulse;
    msi_en_d  = |pending_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      retry_q   <= '0;
      tmo_q     <= '0;
      bo_q      <= '0;
      msinum_q  <= '0;
      msi_req_q <= 1'b0;
      msi_en_q  <= 1'b0;
      drop_q    <= 1'b0;
      cfg_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      bo_q      <= bo_d;
      msinum_q  <= msinum_d;
      msi_req_q <= msi_req_d;
      msi_en_q  <= msi_en_d;
      drop_q    <= drop_d;
      cfg_en_q  <= cfg_msi_enable;
    end
  end

  assign msi_en      = msi_en_q;
  assign msi_req     = msi_req_q;
  assign msinum      = msinum_q;
  assign pending     = pending_q;
  assign irq_dropped = drop_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gowin_msi_requester.sv
`default_nettype none
// ============================================================================
// tb_gowin_msi_requester: scoreboard bench; a round-robin service-order model
// predicts each MSI vector, a monitor pops and compares on every request.
// Revision: 1.0
// ============================================================================
module tb_gowin_msi_requester;

  localparam int N = 4;
  localparam int T = 8;
  localparam int B = 4;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_msi_enable = 1'b0;
  logic [N-1:0] irq_pulse = '0;
  logic         ack_man = 1'b0;
  logic         ack_auto = 1'b0;
  logic         msi_ack;
  logic         msi_en, msi_req, irq_dropped, busy;
  logic [4:0]   msinum;
  logic [N-1:0] pending;

  assign msi_ack = ack_man | ack_auto;

  gowin_msi_requester #(
    .C_NUM_VECTORS(N), .C_ACK_TIMEOUT(T), .C_BACKOFF(B), .C_RETRY_LIMIT(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_msi_enable(cfg_msi_enable),
    .irq_pulse(irq_pulse), .msi_en(msi_en), .msi_req(msi_req),
    .msinum(msinum), .msi_ack(msi_ack), .pending(pending),
    .irq_dropped(irq_dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  int         exp_q[$];
  int         model_ptr = 0;
  bit         auto_ack = 1'b0;
  int         drop_cnt = 0;
  bit         prev_req = 1'b0;
  logic [4:0] held_num = '0;
  int         exp_v;
  int         ack_dly;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin service order of a batch of vectors all pending at once.
  task automatic push_order(input logic [N-1:0] mask);
    int last = -1;
    for (int i = 0; i < N; i++) begin
      int v = (model_ptr + i) % N;
      if (mask[v]) begin
        exp_q.push_back(v);
        last = v;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % N;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    irq_pulse = mask;
    tick();
    irq_pulse = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || msi_req || pending != '0) && n < 1000) begin
      tick();
      n++;
    end
    compared++;
    if (n >= 1000) begin
      mismatched++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (msi_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_req: got msinum %0d, required no request at %0t", msinum, $time);
        end else begin
          exp_v = exp_q.pop_front();
          check("req_vector", 32'(msinum), exp_v);
          check("busy_during_req", 32'(busy), 1);
        end
      end else if (msi_req && prev_req && msinum !== held_num) begin
        compared++;
        mismatched++;
        $display("FAIL msinum_stable: got %0d, required %0d", msinum, held_num);
      end
      if (irq_dropped) drop_cnt++;
      prev_req = msi_req;
      held_num = msinum;
    end
  end

  // Core model: acknowledges each request after a short random delay.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rst_n && msi_req) begin
        ack_dly = $urandom_range(0, 3);
        @(posedge clk); #1;
        repeat (ack_dly) begin @(posedge clk); #1; end
        ack_auto = 1'b1;
        @(posedge clk); #1;
        ack_auto = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, low, high, drops0, first;
    logic [N-1:0] m1, m2, mask;

    // Reset state
    repeat (3) tick();
    check("rst_msi_en", 32'(msi_en), 0);
    check("rst_msi_req", 32'(msi_req), 0);
    check("rst_msinum", 32'(msinum), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_dropped", 32'(irq_dropped), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cfg_msi_enable = 1'b1;
    tick(); tick();

    // Simultaneous pulses served 0,1,3, then wrap
    auto_ack = 1'b1;
    push_order(4'b1011);
    pulse(4'b1011);
    check("batch_pending", 32'(pending), 32'hB);
    wait_idle("batch_1011");
    push_order(4'b0011);
    pulse(4'b0011);
    wait_idle("batch_wrap");
    auto_ack = 1'b0;
    tick();

    // Latency of a single request and its ack
    push_order(4'b0100);
    pulse(4'b0100);
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_req_low", 32'(msi_req), 0);
    tick();
    check("t2_req", 32'(msi_req), 1);
    check("t2_msinum", 32'(msinum), 2);
    tick(); tick(); tick();
    check("t5_req_held", 32'(msi_req), 1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("t6_req_low", 32'(msi_req), 0);
    check("t6_pending", 32'(pending), 0);
    check("t6_msi_en", 32'(msi_en), 1);
    tick();
    check("t7_msi_en", 32'(msi_en), 0);
    check("t7_busy", 32'(busy), 0);

    // Coalescing, and a pulse coinciding with the ack
    push_order(4'b0010);
    irq_pulse = 4'b0010;
    tick(); tick(); tick();
    irq_pulse = '0;
    tick(); tick();
    push_order(4'b0010);
    ack_man = 1'b1;
    irq_pulse = 4'b0010;
    tick();
    ack_man = 1'b0;
    irq_pulse = '0;
    check("ack_pulse_pending", 32'(pending), 32'h2);
    auto_ack = 1'b1;
    wait_idle("coalesce");
    auto_ack = 1'b0;
    check("coalesce_queue", exp_q.size(), 0);

    // Disabled: pending accumulates, stray ack ignored, enable releases
    cfg_msi_enable = 1'b0;
    tick();
    pulse(4'b1000);
    check("dis_pending", 32'(pending), 32'h8);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    repeat (3) tick();
    check("dis_no_req", 32'(msi_req), 0);
    check("dis_msi_en", 32'(msi_en), 1);
    check("dis_pending_kept", 32'(pending), 32'h8);
    push_order(4'b1000);
    cfg_msi_enable = 1'b1;
    tick();
    check("en_s1_req", 32'(msi_req), 0);
    tick();
    check("en_s2_req", 32'(msi_req), 1);
    check("en_s2_msinum", 32'(msinum), 3);
    auto_ack = 1'b1;
    wait_idle("enable");
    auto_ack = 1'b0;

    // Timeout, back-off, retry limit and drop
    v = $urandom_range(0, N - 1);
    drops0 = drop_cnt;
    for (int i = 0; i < R; i++) exp_q.push_back(v);
    model_ptr = (v + 1) % N;
    pulse(N'(1 << v));
    for (int w = 0; w < R; w++) begin
      low = 0;
      while (!msi_req && low < 40) begin tick(); low++; end
      if (w > 0) begin
        compared++;
        if (low < B || low > B + 1) begin
          mismatched++;
          $display("FAIL backoff_gap: got %0d low cycles, required %0d..%0d", low, B, B + 1);
        end
      end
      high = 0;
      while (msi_req && high < 40) begin tick(); high++; end
      check("req_window", high, T);
    end
    wait_idle("drop");
    check("drop_pulses", drop_cnt - drops0, 1);
    check("drop_pending", 32'(pending), 0);
    repeat (10) tick();

    // Ack on the final timeout cycle is a success
    v = $urandom_range(0, N - 1);
    drops0 = drop_cnt;
    push_order(N'(1 << v));
    pulse(N'(1 << v));
    tick();
    repeat (T - 1) tick();
    check("late_req_high", 32'(msi_req), 1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("late_ack_req", 32'(msi_req), 0);
    check("late_ack_pending", 32'(pending), 0);
    wait_idle("late_ack");
    check("late_ack_nodrop", drop_cnt - drops0, 0);

    // Randomized batches with coalescing pulses during service
    for (int it = 0; it < 15; it++) begin
      int n;
      cfg_msi_enable = 1'b0;
      tick();
      m1 = N'($urandom_range(1, (1 << N) - 1));
      m2 = N'($urandom_range(0, (1 << N) - 1));
      irq_pulse = m1;
      tick();
      irq_pulse = m2;
      tick();
      irq_pulse = '0;
      check("rand_pending", 32'(pending), 32'(m1 | m2));
      push_order(m1 | m2);
      cfg_msi_enable = 1'b1;
      auto_ack = 1'b1;
      n = 0;
      tick();
      while ((busy || msi_req || pending != '0) && n < 500) begin
        if (exp_q.size() >= 2 && $urandom_range(0, 3) == 0)
          irq_pulse[exp_q[$urandom_range(1, exp_q.size() - 1)]] = 1'b1;
        tick();
        irq_pulse = '0;
        n++;
      end
      auto_ack = 1'b0;
      check("rand_drained", exp_q.size(), 0);
    end

    // Asynchronous reset mid-request
    mask = 4'b0101;
    first = -1;
    for (int i = 0; i < N; i++)
      if (first < 0 && mask[(model_ptr + i) % N]) first = (model_ptr + i) % N;
    exp_q.push_back(first);
    pulse(mask);
    tick(); tick();
    check("prerst_req", 32'(msi_req), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(msi_req), 0);
    check("arst_pending", 32'(pending), 0);
    check("arst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    repeat (20) tick();
    check("postrst_no_req", 32'(msi_req), 0);
    push_order(4'b0010);
    auto_ack = 1'b1;
    pulse(4'b0010);
    wait_idle("postrst");
    auto_ack = 1'b0;
    repeat (5) tick();
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gowin_msi_requester.md
Name: gowin_msi_requester

Overview:
- Interrupt-request initiator that drives the Gowin PCIe hard controller's MSI request port (int_status/int_req/int_msinum/int_ack).
- Collects per-vector interrupt pulses from the RIFFA endpoint and channel logic, and latches them as sticky pending bits.
- Issues one MSI request at a time with round-robin arbitration, holding each request until the core acknowledges it.
- Retries on acknowledge timeout and drops a vector after a retry limit; it sits between the RIFFA wrapper interrupt outputs and the SerDes_Top PCIe controller.

Parameters:
- C_NUM_VECTORS, 4, number of interrupt sources/MSI vectors; legal range 1..32; vector i maps to msinum i.
- C_ACK_TIMEOUT, 1024, cycles msi_req may stay high without msi_ack before it is withdrawn; minimum 2.
- C_BACKOFF, 16, idle cycles after a timeout before the next request; minimum 1.
- C_RETRY_LIMIT, 3, consecutive timeouts on one vector before that vector is dropped; minimum 1.

Ports:
- clk, input, 1, core clock; same clock as the PCIe TL clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- cfg_msi_enable, input, 1, MSI enable bit from config space; requests are issued only while high.
- irq_pulse, input, C_NUM_VECTORS, one-cycle interrupt events, one bit per vector.
- msi_en, output, 1, interrupt status to the core (int_status_i); equals OR of pending, registered.
- msi_req, output, 1, MSI request to the core (int_req_i).
- msinum, output, 5, vector number (int_msinum_i); stable while msi_req is high.
- msi_ack, input, 1, acknowledge from the core (int_ack_o).
- pending, output, C_NUM_VECTORS, sticky pending bits.
- irq_dropped, output, 1, one-cycle pulse when a vector is abandoned after C_RETRY_LIMIT timeouts.
- busy, output, 1, high in every state other than IDLE.

Behaviour:
Reset values:
- msi_en=0, msi_req=0, msinum=0, pending=0, irq_dropped=0, busy=0.
- Retry count and timeout counter cleared; round-robin pointer set to 0; FSM=IDLE.
- Reset asserted mid-request drops msi_req immediately and discards all pending bits.

Pending register:
- irq_pulse[i]=1 at cycle t sets pending[i] at t+1.
- Repeated pulses while the bit is already set coalesce into one MSI.
- A clear (ack or drop) and a new pulse on the same vector in the same cycle leaves the bit set, so the new event is not lost.

FSM states: IDLE, REQ, GAP, BACKOFF.
- IDLE: if cfg_msi_enable && |pending, select the first set bit at or after the round-robin pointer (wrapping from C_NUM_VECTORS-1 to 0). Register msinum=sel and msi_req=1, and go to REQ. Earliest msi_req is t+2 after the irq_pulse at t.
- REQ: msi_req=1 and msinum held constant.
  - msi_ack=1: clear pending[sel], set pointer=sel+1 (mod C_NUM_VECTORS), clear retry count; msi_req=0 next cycle; go to GAP.
  - Timeout counter reaches C_ACK_TIMEOUT-1 without ack: msi_req=0 next cycle; retry count +1.
    - If the retry count is now C_RETRY_LIMIT: clear pending[sel], pulse irq_dropped, clear retry count, advance the pointer.
    - Go to BACKOFF in both cases.
  - Ack arriving on the timeout cycle takes priority and is treated as success.
- GAP: one cycle with msi_req=0 (the core requires req low between requests), then IDLE.
- BACKOFF: C_BACKOFF cycles with msi_req=0, then IDLE. The retried vector re-enters arbitration normally; the pointer is not advanced unless the vector was dropped.

Other rules:
- msi_ack outside REQ is ignored.
- cfg_msi_enable falling during REQ does not withdraw the request; the request completes by ack or timeout. No new request starts while it is low, and pending bits keep accumulating.
- Timeout counter width is clog2(C_ACK_TIMEOUT); it is cleared on entry to REQ.
- msinum upper bits beyond clog2(C_NUM_VECTORS) are zero.

Test Plan:
- C_NUM_VECTORS=4: irq_pulse=4'b0100 at t with cfg_msi_enable=1 -> msi_req=1 and msinum=2 at t+2; ack at t+5 -> msi_req=0 at t+6, pending=0, msi_en=0 at t+7.
- irq_pulse=4'b1011 simultaneously -> served order 0, 1, 3; each request is separated by at least one req-low cycle; pointer wraps so a later pulse on 0 is served after 3.
- Three pulses on vector 1 before ack -> exactly one MSI; a pulse on 1 in the same cycle as its ack -> a second MSI follows.
- No ack, C_ACK_TIMEOUT=8, C_BACKOFF=4, C_RETRY_LIMIT=3 -> three request windows of 8 cycles each, 4 idle cycles between them; irq_dropped pulses once; pending[sel]=0.
- cfg_msi_enable=0 with a pulse on vector 3 -> no msi_req, pending=4'b1000 and msi_en=1; enable raised -> request with msinum=3 two cycles later.
- rst_n low for 1 cycle while msi_req=1 -> msi_req, pending and busy are 0 asynchronously; no request after release until a new pulse arrives.
